// File: rtl/data_mem_responder.sv
// Stage-three data-memory responder: posted-store write buffer
// with youngest-entry forwarding and fixed-latency loads.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 2,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic                          req_we,
  input  logic [15:0]                   req_addr,
  input  logic [15:0]                   req_wdata,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [15:0]                   rsp_data,
  output logic                          halt_sys,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = $clog2(WBUF_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic {
    IDLE,
    READ_WAIT
  } state_t;

  state_t state;

  logic [15:0]           mem     [DEPTH];
  logic [DEPTH_LOG2-1:0] wb_addr [WBUF_DEPTH];
  logic [15:0]           wb_data [WBUF_DEPTH];

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [2:0]            wait_cnt;
  logic [15:0]           pend;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  wb_full;
  logic                  accept;
  logic                  push;
  logic                  load;
  logic                  drain;
  logic [15:0]           ld_data;

  assign idx        = req_addr[DEPTH_LOG2-1:0];
  assign wb_full    = (count == CW'(WBUF_DEPTH));
  assign req_ready  = (state == IDLE) && (!req_we || !wb_full);
  assign halt_sys   = req_valid && !req_ready;
  assign accept     = req_valid && req_ready;
  assign push       = accept && req_we;
  assign load       = accept && !req_we;
  assign drain      = !accept && (count != '0);
  assign wbuf_count = count;

  // Load data: array word, overridden oldest-to-youngest by matching buffer entries
  always_comb begin
    logic [PW-1:0] slot;
    slot    = '0;
    ld_data = mem[idx];
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (wb_addr[slot] == idx))
        ld_data = wb_data[slot];
    end
  end

  // Write-buffer FIFO: push on accepted store, pop on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (push) begin
      wb_addr[tail] <= idx;
      wb_data[tail] <= req_wdata;
      tail          <= tail + 1'b1;
      count         <= count + 1'b1;
    end else if (drain) begin
      head  <= head + 1'b1;
      count <= count - 1'b1;
    end
  end

  // Word array: cleared on reset, written only by the drain path
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (drain) begin
      mem[wb_addr[head]] <= wb_data[head];
    end
  end

  // Load sequencing: capture at accept, pulse rsp_valid READ_LAT cycles later
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      wait_cnt  <= '0;
      pend      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (READ_LAT == 1) begin
              rsp_valid <= 1'b1;
              rsp_data  <= ld_data;
            end else begin
              state    <= READ_WAIT;
              pend     <= ld_data;
              wait_cnt <= 3'(READ_LAT - 1);
            end
          end
        end
        READ_WAIT: begin
          if (wait_cnt == 3'd1) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= pend;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder:
// latency, forwarding, buffer full, aliasing, reset mid-read.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        halt_sys;
  logic [2:0]  wbuf_count;

  int n_chk  = 0;
  int n_fail = 0;

  data_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .halt_sys   (halt_sys),
    .wbuf_count (wbuf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic do_store(input logic [15:0] a,
                          input logic [15:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("store_timeout", 0, 1);
    tick();
    idle_bus();
  endtask

  task automatic do_load(input string tag,
                         input logic [15:0] a,
                         input logic [15:0] exp);
    int n;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    idle_bus();
    n = 1;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 2);
    check(tag, rsp_data, exp);
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready", req_ready, 1);
    check("rst_halt", halt_sys, 0);
    check("rst_count", wbuf_count, 0);

    // 1: load after reset, latency 2
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0005;
    #1;
    check("t1_ready_T", req_ready, 1);
    tick();
    idle_bus();
    #1;
    check("t1_ready_T1", req_ready, 0);
    check("t1_valid_T1", rsp_valid, 0);
    tick();
    check("t1_valid_T2", rsp_valid, 1);
    check("t1_data_T2", rsp_data, 16'h0000);
    tick();
    check("t1_valid_pulse", rsp_valid, 0);

    // 2: store then immediate load forwards
    do_store(16'h0010, 16'h1234);
    check("t2_count", wbuf_count, 1);
    do_load("t2_fwd", 16'h0010, 16'h1234);
    tick();

    // 3: youngest matching entry wins
    do_store(16'h0030, 16'h1111);
    do_store(16'h0030, 16'h2222);
    do_load("t3_young", 16'h0030, 16'h2222);
    repeat (6) tick();
    check("t3_drained", wbuf_count, 0);

    // 4: fill buffer with back-to-back stores
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0020 + 16'(i);
      req_wdata = 16'h0A20 + 16'(i);
      #1;
      check("t4_ready_fill", req_ready, 1);
      tick();
    end
    req_addr  = 16'h0024;
    req_wdata = 16'h0A24;
    #1;
    check("t4_count_full", wbuf_count, 4);
    check("t4_ready_full", req_ready, 0);
    check("t4_halt_full", halt_sys, 1);
    tick();
    check("t4_count_drain", wbuf_count, 3);
    check("t4_ready_next", req_ready, 1);
    check("t4_halt_next", halt_sys, 0);
    tick();
    idle_bus();
    check("t4_count_push", wbuf_count, 4);
    repeat (8) tick();
    check("t4_empty", wbuf_count, 0);
    do_load("t4_mem22", 16'h0022, 16'h0A22);
    do_load("t4_mem24", 16'h0024, 16'h0A24);

    // 5: address aliasing through the array
    do_store(16'h0105, 16'hABCD);
    repeat (8) tick();
    check("t5_count", wbuf_count, 0);
    do_load("t5_alias", 16'h0005, 16'hABCD);

    // 6: reset during a pending read
    do_store(16'h0040, 16'h5555);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0040;
    #1;
    check("t6_ready_T", req_ready, 1);
    tick();
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_valid", rsp_valid, 0);
    check("t6_data", rsp_data, 0);
    check("t6_ready", req_ready, 1);
    check("t6_halt", halt_sys, 0);
    check("t6_count", wbuf_count, 0);
    tick();
    check("t6_no_late_rsp", rsp_valid, 0);
    do_load("t6_lost_store", 16'h0040, 16'h0000);
    do_load("t6_cleared", 16'h0005, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
